// File: rtl/uart_tx_queue_pkg.sv
// Shared definitions for the UART transmit queue: launch sequencer states and defaults.
package uart_tx_queue_pkg;

    localparam int DEFAULT_DEPTH = 16;
    localparam int DATA_W        = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_ARM    = 2'd2,
        ST_WAIT   = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x 8 storage for the transmit queue: synchronous write, asynchronous read.
module uart_fifo_mem
    import uart_tx_queue_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write port; left unreset so the array can sit in distributed RAM
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue plus launch sequencer feeding the serial transmitter. Bytes are
// buffered in a FIFO and handed to the transmitter one at a time with a
// one-cycle tx_start pulse whenever the transmitter is idle.
module uart_tx_queue
    import uart_tx_queue_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              flush_i,
    input  logic              ovf_clr_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [AW:0]       level_o,
    output logic              overflow_o,
    output logic              tx_start_o,
    output logic [DATA_W-1:0] tx_data_o,
    input  logic              tx_busy_i
);

    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              overflow_q, overflow_d;
    tx_state_e         state_q;
    logic              tx_start_q;
    logic [DATA_W-1:0] tx_data_q;
    logic [DATA_W-1:0] rd_data;
    logic              push;
    logic              pop;

    assign full_o     = (count_q == DEPTH_CNT);
    assign empty_o    = (count_q == '0);
    assign level_o    = count_q;
    assign overflow_o = overflow_q;
    assign tx_start_o = tx_start_q;
    assign tx_data_o  = tx_data_q;

    // A flush discards both the queue and any push arriving in the same cycle,
    // and also suppresses a launch that would otherwise start on that edge.
    assign push = wr_en_i & ~full_o & ~flush_i;
    assign pop  = (state_q == ST_IDLE) & ~empty_o & ~tx_busy_i & ~flush_i;

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    // Next-state for pointers, level and the sticky overflow flag
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (flush_i) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
        if (wr_en_i && full_o) begin
            overflow_d = 1'b1;
        end else if (ovf_clr_i) begin
            overflow_d = 1'b0;
        end
    end

    // Queue bookkeeping registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Launch sequencer: pop and pulse tx_start, hold a guard cycle, then wait for the line
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        state_q    <= ST_LAUNCH;
                        tx_start_q <= 1'b1;
                        tx_data_q  <= rd_data;
                    end
                end
                ST_LAUNCH: begin
                    tx_start_q <= 1'b0;
                    state_q    <= ST_ARM;
                end
                ST_ARM: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!tx_busy_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    tx_start_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    // The level can never leave 0..DEPTH and a launch never pops an empty queue
    assert property (@(posedge clk_i) disable iff (reset_i) count_q <= DEPTH_CNT);
    assert property (@(posedge clk_i) disable iff (reset_i) !(pop && empty_o));

endmodule

// File: tb/tb_uart_tx_queue.sv
// Testbench for uart_tx_queue: a queue-based reference model plus a simple
// transmitter model that raises tx_busy for a random frame time after each start.
module tb_uart_tx_queue;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          wr_en_i;
    logic [7:0]    wr_data_i;
    logic          flush_i;
    logic          ovf_clr_i;
    logic          full_o;
    logic          empty_o;
    logic [AW:0]   level_o;
    logic          overflow_o;
    logic          tx_start_o;
    logic [7:0]    tx_data_o;
    logic          tx_busy_i;

    int            nChecks = 0;
    int            nFails = 0;
    logic [7:0]    modelQueue[$];
    logic          modelOvf;
    logic [7:0]    gotBytes[$];
    logic [7:0]    expBytes[$];
    int            illegalLaunches = 0;
    int            stallEvents = 0;
    int            sinceLaunch = 100;
    int            stallRun = 0;
    int            busyLeft = 0;
    bit            startPrev = 1'b0;
    bit            holdBusy = 1'b0;
    int            frameMin = 2;
    int            frameMax = 8;

    uart_tx_queue #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .wr_en_i    (wr_en_i),
        .wr_data_i  (wr_data_i),
        .flush_i    (flush_i),
        .ovf_clr_i  (ovf_clr_i),
        .full_o     (full_o),
        .empty_o    (empty_o),
        .level_o    (level_o),
        .overflow_o (overflow_o),
        .tx_start_o (tx_start_o),
        .tx_data_o  (tx_data_o),
        .tx_busy_i  (tx_busy_i)
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock, then update the queue model, the launch log and the transmitter model
    task automatic tick();
        bit         preFull;
        bit         preBusy;
        bit         preWr;
        bit         preFlush;
        bit         preClr;
        logic [7:0] preData;
        preFull  = (modelQueue.size() == DEPTH);
        preBusy  = tx_busy_i;
        preWr    = wr_en_i;
        preFlush = flush_i;
        preClr   = ovf_clr_i;
        preData  = wr_data_i;
        @(posedge clk_i);
        #1;
        if (reset_i) return;
        sinceLaunch++;
        if (tx_start_o) begin
            gotBytes.push_back(tx_data_o);
            if (modelQueue.size() == 0 || preBusy || sinceLaunch < 4) illegalLaunches++;
            if (modelQueue.size() != 0) expBytes.push_back(modelQueue.pop_front());
            sinceLaunch = 0;
            stallRun = 0;
        end else if (preBusy || preFlush || modelQueue.size() == 0) begin
            stallRun = 0;
        end else begin
            stallRun++;
            if (stallRun > 6) begin
                stallEvents++;
                stallRun = 0;
            end
        end
        if (preFlush) modelQueue.delete();
        else if (preWr && !preFull) modelQueue.push_back(preData);
        if (preWr && preFull) modelOvf = 1'b1;
        else if (preClr) modelOvf = 1'b0;
        if (busyLeft > 0) busyLeft--;
        if (startPrev) busyLeft = int'($urandom_range(frameMax, frameMin));
        startPrev = tx_start_o;
        tx_busy_i = holdBusy || (busyLeft > 0);
    endtask

    // Run until the model queue is empty and the transmitter has gone quiet
    task automatic drain(input int budget, output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        while (!ok && n < budget) begin
            if (modelQueue.size() == 0 && !tx_busy_i && !tx_start_o && sinceLaunch > 4) ok = 1'b1;
            else begin
                tick();
                n++;
            end
        end
        if (ok) begin
            tick();
            tick();
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        wr_en_i = 1'b0;
        wr_data_i = 8'h00;
        flush_i = 1'b0;
        ovf_clr_i = 1'b0;
        tx_busy_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        nChecks++; if (level_o !== '0) begin nFails++; $display("[TB] FAIL reset_level: got %0d expected 0", level_o); end
        nChecks++; if (empty_o !== 1'b1) begin nFails++; $display("[TB] FAIL reset_empty: got %b expected 1", empty_o); end
        nChecks++; if (full_o !== 1'b0) begin nFails++; $display("[TB] FAIL reset_full: got %b expected 0", full_o); end
        nChecks++; if (overflow_o !== 1'b0) begin nFails++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow_o); end
        nChecks++; if (tx_start_o !== 1'b0) begin nFails++; $display("[TB] FAIL reset_tx_start: got %b expected 0", tx_start_o); end
        nChecks++; if (tx_data_o !== 8'h00) begin nFails++; $display("[TB] FAIL reset_tx_data: got %h expected 00", tx_data_o); end
        modelQueue.delete();
        modelOvf = 1'b0;
        reset_i = 1'b0;
    endtask

    task automatic test_single_push();
        bit ok;
        frameMin = 3;
        frameMax = 8;
        wr_data_i = 8'hA5;
        wr_en_i = 1'b1;
        tick();
        wr_en_i = 1'b0;
        nChecks++; if (tx_start_o !== 1'b0) begin nFails++; $display("[TB] FAIL single_early_start: got %b expected 0", tx_start_o); end
        nChecks++; if (level_o !== 5'd1) begin nFails++; $display("[TB] FAIL single_level: got %0d expected 1", level_o); end
        tick();
        nChecks++; if (tx_start_o !== 1'b1) begin nFails++; $display("[TB] FAIL single_start: got %b expected 1", tx_start_o); end
        nChecks++; if (tx_data_o !== 8'hA5) begin nFails++; $display("[TB] FAIL single_data: got %h expected a5", tx_data_o); end
        nChecks++; if (empty_o !== 1'b1) begin nFails++; $display("[TB] FAIL single_empty_after: got %b expected 1", empty_o); end
        drain(200, ok);
        nChecks++; if (!ok) begin nFails++; $display("[TB] FAIL single_drain: got timeout expected idle"); end
    endtask

    task automatic test_burst();
        bit ok;
        frameMin = 30;
        frameMax = 30;
        for (int i = 0; i < 17; i++) begin
            wr_data_i = 8'(i);
            wr_en_i = 1'b1;
            tick();
            if (i == 15) begin
                nChecks++; if (level_o !== 5'd15) begin nFails++; $display("[TB] FAIL burst_level16: got %0d expected 15", level_o); end
                nChecks++; if (full_o !== 1'b0) begin nFails++; $display("[TB] FAIL burst_not_full: got %b expected 0", full_o); end
            end
            if (i == 16) begin
                nChecks++; if (level_o !== 5'd16) begin nFails++; $display("[TB] FAIL burst_level17: got %0d expected 16", level_o); end
                nChecks++; if (full_o !== 1'b1) begin nFails++; $display("[TB] FAIL burst_full: got %b expected 1", full_o); end
                nChecks++; if (overflow_o !== 1'b0) begin nFails++; $display("[TB] FAIL burst_no_overflow: got %b expected 0", overflow_o); end
            end
        end
        wr_en_i = 1'b0;
        frameMin = 2;
        frameMax = 8;
        drain(2000, ok);
        nChecks++; if (!ok) begin nFails++; $display("[TB] FAIL burst_drain: got timeout expected idle"); end
    endtask

    task automatic test_overflow();
        bit ok;
        holdBusy = 1'b1;
        tx_busy_i = 1'b1;
        for (int i = 0; i < 17; i++) begin
            wr_data_i = 8'($urandom);
            wr_en_i = 1'b1;
            tick();
            if (i == 15) begin
                nChecks++; if (full_o !== 1'b1) begin nFails++; $display("[TB] FAIL ovf_full: got %b expected 1", full_o); end
                nChecks++; if (overflow_o !== 1'b0) begin nFails++; $display("[TB] FAIL ovf_early: got %b expected 0", overflow_o); end
            end
        end
        wr_en_i = 1'b0;
        nChecks++; if (overflow_o !== 1'b1) begin nFails++; $display("[TB] FAIL ovf_set: got %b expected 1", overflow_o); end
        nChecks++; if (level_o !== 5'd16) begin nFails++; $display("[TB] FAIL ovf_level: got %0d expected 16", level_o); end
        tick();
        nChecks++; if (overflow_o !== 1'b1) begin nFails++; $display("[TB] FAIL ovf_sticky: got %b expected 1", overflow_o); end
        wr_en_i = 1'b1;
        ovf_clr_i = 1'b1;
        tick();
        wr_en_i = 1'b0;
        nChecks++; if (overflow_o !== 1'b1) begin nFails++; $display("[TB] FAIL ovf_set_wins: got %b expected 1", overflow_o); end
        tick();
        ovf_clr_i = 1'b0;
        nChecks++; if (overflow_o !== 1'b0) begin nFails++; $display("[TB] FAIL ovf_clear: got %b expected 0", overflow_o); end
        holdBusy = 1'b0;
        drain(2000, ok);
        nChecks++; if (!ok) begin nFails++; $display("[TB] FAIL ovf_drain: got timeout expected idle"); end
    endtask

    task automatic test_push_pop_wrap();
        bit ok;
        holdBusy = 1'b1;
        tx_busy_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data_i = 8'($urandom);
            wr_en_i = 1'b1;
            tick();
        end
        nChecks++; if (level_o !== 5'd3) begin nFails++; $display("[TB] FAIL pp_level_before: got %0d expected 3", level_o); end
        holdBusy = 1'b0;
        tx_busy_i = 1'b0;
        wr_data_i = 8'($urandom);
        tick();
        wr_en_i = 1'b0;
        nChecks++; if (tx_start_o !== 1'b1) begin nFails++; $display("[TB] FAIL pp_launch: got %b expected 1", tx_start_o); end
        nChecks++; if (level_o !== 5'd3) begin nFails++; $display("[TB] FAIL pp_level_same: got %0d expected 3", level_o); end
        drain(2000, ok);
        nChecks++; if (!ok) begin nFails++; $display("[TB] FAIL pp_drain: got timeout expected idle"); end
    endtask

    task automatic test_flush();
        bit         ok;
        int         launchesBefore;
        logic [7:0] inflight;
        frameMin = 40;
        frameMax = 40;
        inflight = 8'h00;
        for (int i = 0; i < 6; i++) begin
            wr_data_i = 8'h40 + 8'(i);
            if (i == 0) inflight = wr_data_i;
            wr_en_i = 1'b1;
            tick();
        end
        nChecks++; if (level_o !== 5'd5) begin nFails++; $display("[TB] FAIL flush_level_before: got %0d expected 5", level_o); end
        flush_i = 1'b1;
        wr_data_i = 8'hEE;
        tick();
        flush_i = 1'b0;
        wr_en_i = 1'b0;
        nChecks++; if (level_o !== 5'd0) begin nFails++; $display("[TB] FAIL flush_level: got %0d expected 0", level_o); end
        nChecks++; if (empty_o !== 1'b1) begin nFails++; $display("[TB] FAIL flush_empty: got %b expected 1", empty_o); end
        launchesBefore = gotBytes.size();
        repeat (60) tick();
        nChecks++; if (gotBytes.size() !== launchesBefore) begin nFails++; $display("[TB] FAIL flush_no_start: got %0d launches expected %0d", gotBytes.size(), launchesBefore); end
        nChecks++; if (tx_data_o !== inflight) begin nFails++; $display("[TB] FAIL flush_inflight_data: got %h expected %h", tx_data_o, inflight); end
        frameMin = 2;
        frameMax = 8;
        drain(500, ok);
        nChecks++; if (!ok) begin nFails++; $display("[TB] FAIL flush_drain: got timeout expected idle"); end
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        int launchesBefore;
        frameMin = 40;
        frameMax = 40;
        for (int i = 0; i < 4; i++) begin
            wr_data_i = 8'h81 + 8'(i);
            wr_en_i = 1'b1;
            tick();
        end
        #2;
        reset_i = 1'b1;
        #1;
        nChecks++; if (level_o !== '0) begin nFails++; $display("[TB] FAIL async_level: got %0d expected 0", level_o); end
        nChecks++; if (empty_o !== 1'b1) begin nFails++; $display("[TB] FAIL async_empty: got %b expected 1", empty_o); end
        nChecks++; if (tx_start_o !== 1'b0) begin nFails++; $display("[TB] FAIL async_tx_start: got %b expected 0", tx_start_o); end
        nChecks++; if (tx_data_o !== 8'h00) begin nFails++; $display("[TB] FAIL async_tx_data: got %h expected 00", tx_data_o); end
        wr_en_i = 1'b0;
        modelQueue.delete();
        modelOvf = 1'b0;
        startPrev = 1'b0;
        sinceLaunch = 100;
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        launchesBefore = gotBytes.size();
        repeat (30) tick();
        nChecks++; if (gotBytes.size() !== launchesBefore) begin nFails++; $display("[TB] FAIL async_no_start: got %0d launches expected %0d", gotBytes.size(), launchesBefore); end
        frameMin = 2;
        frameMax = 8;
        wr_data_i = 8'h5A;
        wr_en_i = 1'b1;
        tick();
        wr_en_i = 1'b0;
        drain(500, ok);
        nChecks++; if (!ok) begin nFails++; $display("[TB] FAIL async_drain: got timeout expected idle"); end
        nChecks++; if (gotBytes.size() !== launchesBefore + 1) begin nFails++; $display("[TB] FAIL async_relaunch: got %0d launches expected %0d", gotBytes.size(), launchesBefore + 1); end
    endtask

    task automatic test_random_traffic();
        bit ok;
        frameMin = 2;
        frameMax = 8;
        for (int i = 0; i < 600; i++) begin
            wr_en_i = ($urandom_range(99, 0) < 45);
            wr_data_i = 8'($urandom);
            flush_i = ($urandom_range(99, 0) < 2);
            ovf_clr_i = ($urandom_range(99, 0) < 5);
            tick();
            nChecks++; if (int'(level_o) !== modelQueue.size()) begin nFails++; $display("[TB] FAIL rand_level @%0d: got %0d expected %0d", i, level_o, modelQueue.size()); end
            nChecks++; if (overflow_o !== modelOvf) begin nFails++; $display("[TB] FAIL rand_overflow @%0d: got %b expected %b", i, overflow_o, modelOvf); end
            nChecks++; if (full_o !== (modelQueue.size() == DEPTH)) begin nFails++; $display("[TB] FAIL rand_full @%0d: got %b expected %b", i, full_o, modelQueue.size() == DEPTH); end
            nChecks++; if (empty_o !== (modelQueue.size() == 0)) begin nFails++; $display("[TB] FAIL rand_empty @%0d: got %b expected %b", i, empty_o, modelQueue.size() == 0); end
        end
        wr_en_i = 1'b0;
        flush_i = 1'b0;
        ovf_clr_i = 1'b0;
        drain(2000, ok);
        nChecks++; if (!ok) begin nFails++; $display("[TB] FAIL rand_drain: got timeout expected idle"); end
    endtask

    task automatic test_launch_order();
        nChecks++; if (gotBytes.size() !== expBytes.size()) begin nFails++; $display("[TB] FAIL order_count: got %0d launches expected %0d", gotBytes.size(), expBytes.size()); end
        for (int i = 0; i < gotBytes.size() && i < expBytes.size(); i++) begin
            nChecks++; if (gotBytes[i] !== expBytes[i]) begin nFails++; $display("[TB] FAIL order_byte %0d: got %h expected %h", i, gotBytes[i], expBytes[i]); end
        end
        nChecks++; if (illegalLaunches !== 0) begin nFails++; $display("[TB] FAIL order_illegal_launch: got %0d expected 0", illegalLaunches); end
        nChecks++; if (stallEvents !== 0) begin nFails++; $display("[TB] FAIL order_stall: got %0d expected 0", stallEvents); end
    endtask

    // Hard stop in case the sequence ever wedges
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scenario sequence
    initial begin
        test_reset();
        test_single_push();
        test_burst();
        test_overflow();
        test_push_pop_wrap();
        test_flush();
        test_reset_mid_burst();
        test_random_traffic();
        test_launch_order();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
